i2c_slave_phy: RTL and testbench
================================

Name: i2c_slave_phy

Overview:
Byte-level I2C responder (target) that answers a 7-bit address on the same open-drain bus the master PHY drives.
- Detects START, repeated START and STOP on the bus.
- Matches the address byte and ACKs a match.
- Delivers received write bytes to the fabric.
- Fetches read bytes from the fabric, stretching SCL while no byte is available.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit bus address the block responds to.
STRETCH_EN, 1, 1: hold SCL low in RD_LOAD until tx_valid_i; 0: never stretch, send 8'hFF if no byte is offered.

Ports:
clk_i  in  1  system clock.
rst_i  in  1  asynchronous active-high reset.
sda_i  in  1  SDA pin level.
sda_o  out  1  constant 0 (open drain).
sda_oe  out  1  1 pulls SDA low.
scl_i  in  1  SCL pin level.
scl_o  out  1  constant 0.
scl_oe  out  1  1 pulls SCL low (stretch).
start_o  out  1  1-cycle pulse on START or repeated START.
stop_o  out  1  1-cycle pulse on STOP.
busy_o  out  1  high from START to STOP.
rw_o  out  1  R/W bit of the last matched address byte (1 = master reads).
rx_data_o  out  8  received write byte.
rx_valid_o  out  1  1-cycle pulse, rx_data_o valid.
tx_data_i  in  8  byte to send on a read.
tx_valid_i  in  1  tx_data_i valid.
tx_ready_o  out  1  block accepts tx_data_i; a transfer occurs when tx_valid_i && tx_ready_o.

Behaviour:
Reset and constant outputs
- Clock is clk_i; reset is rst_i, asynchronous, active-high.
- Reset values: all outputs 0; sda_o and scl_o are constantly 0. Internal filtered levels reset to 1; state resets to IDLE.
- rst_i mid-transfer releases both lines on the next clk_i edge.

Input conditioning
- 2-flop synchroniser, then a 3-tap shift register, then a registered 2-of-3 majority, giving sda_f and scl_f.
- A 1-cycle glitch is rejected.
- A stable pin change appears on the filtered level 4 clk_i cycles later.
- Edges: scl_rise, scl_fall, sda_rise, sda_fall are derived from the filtered levels delayed by 1 cycle.

Bus conditions
- START = sda_fall && scl_f. STOP = sda_rise && scl_f. Both are checked in every state.
- Precedence: START and STOP override any state. START goes to ADDR with the bit counter cleared. STOP goes to IDLE.
- On either condition, sda_oe and scl_oe are released in the same cycle the condition is registered.

Bit timing
- Data is sampled on scl_rise.
- sda_oe changes only on scl_fall, except on release by START/STOP.
- 3-bit bit counter counts MSB first.

States
- IDLE: sda_oe=0, scl_oe=0; wait for START.
- ADDR: shift 8 bits.
  - On the 8th scl_rise, compare bits[7:1] with SLAVE_ADDR.
  - Match: latch rw_o = bit0, then at the next scl_fall set sda_oe=1 and go to ADDR_ACK.
  - Mismatch: go to WAIT_STOP.
- ADDR_ACK: hold sda_oe=1 until the next scl_fall. At that scl_fall:
  - rw_o=0: sda_oe=0, go to WR_DATA.
  - rw_o=1: go to RD_LOAD.
- WR_DATA: shift 8 bits. On the 8th scl_rise:
  - rx_data_o updates and rx_valid_o pulses the following cycle.
  - At the next scl_fall, sda_oe=1 and go to WR_ACK. Every written byte is ACKed.
- WR_ACK: at scl_fall, sda_oe=0, go to WR_DATA.
- RD_LOAD:
  - Entered on scl_fall. scl_oe=1 in the entry cycle when STRETCH_EN=1 and !tx_valid_i.
  - tx_ready_o=1.
  - On transfer: load the shift register, sda_oe = !tx_data_i[7], scl_oe=0, go to RD_DATA.
  - STRETCH_EN=0 with no tx_valid_i: load 8'hFF in the entry cycle.
- RD_DATA:
  - On each scl_fall, drive the next bit (sda_oe = !bit).
  - After the 8th bit's scl_fall, sda_oe=0 and go to RD_ACK.
- RD_ACK: sample SDA at scl_rise.
  - Low (ACK): at the next scl_fall go to RD_LOAD.
  - High (NACK): go to WAIT_STOP.
- WAIT_STOP: all lines released; wait for START or STOP.

Handshake outputs
- tx_ready_o is high only in RD_LOAD before the transfer.
- tx_valid_i outside RD_LOAD is ignored and not consumed.

Bus status and arbitration
- busy_o is set on START and cleared on STOP.
- There is no arbitration logic; the responder only pulls lines low.

Test Plan:
- Write 0xA0 (0x50, W), 0x12, 0x34, STOP -> ACK on all 3 bytes; rx_valid_o pulses with 0x12 then 0x34; start_o and stop_o each pulse once; busy_o returns to 0.
- Address 0xA2 (0x51) -> no ACK (SDA high at the 9th clock), no rx_valid_o, block sits in WAIT_STOP until STOP.
- Read 0xA1 with tx_valid_i delayed 50 cycles, STRETCH_EN=1 -> scl_oe=1 for about 50 cycles; 0x5A appears MSB-first on SDA; master NACK leads to WAIT_STOP and tx_ready_o stays 0.
- Repeated START after writing 0x12 to 0x50, then 0xA1 read -> start_o pulses twice, rw_o=1, tx_ready_o asserts.
- STOP after 3 bits of a data byte and a 1-cycle SDA glitch while SCL is high -> the STOP returns the block to IDLE with no rx_valid_o; the glitch produces no start_o or stop_o.
- rst_i asserted while sda_oe=1 during an ACK -> sda_oe=0 and scl_oe=0 on the next edge; the following transfer works normally.

Source files
------------

// File: rtl/i2c_slave_phy.sv
// Byte-level I2C target PHY: filters SDA/SCL, detects START/STOP, matches a
// 7-bit address, hands write bytes to the fabric and fetches read bytes,
// stretching SCL while no read byte is available.
module i2c_slave_phy #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter bit         STRETCH_EN = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_oe,
    input  logic       scl_i,
    output logic       scl_o,
    output logic       scl_oe,
    output logic       start_o,
    output logic       stop_o,
    output logic       busy_o,
    output logic       rw_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o
);

    typedef enum logic [3:0] {
        StIdle, StAddr, StAddrAck, StWrData, StWrAck,
        StRdLoad, StRdData, StRdAck, StWaitStop
    } state_e;

    // Input conditioning: sync[1] is the newest tap of the 3-tap majority window.
    logic [1:0] sda_sync_q, scl_sync_q, sda_tap_q, scl_tap_q;
    logic       sda_f_q, scl_f_q, sda_d_q, scl_d_q;
    logic       sda_maj, scl_maj;

    assign sda_maj = (sda_sync_q[1] & sda_tap_q[0]) | (sda_sync_q[1] & sda_tap_q[1]) |
                     (sda_tap_q[0] & sda_tap_q[1]);
    assign scl_maj = (scl_sync_q[1] & scl_tap_q[0]) | (scl_sync_q[1] & scl_tap_q[1]) |
                     (scl_tap_q[0] & scl_tap_q[1]);

    // Synchronise, glitch-filter and delay both bus lines; idle bus level is 1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sda_sync_q <= 2'b11;
            scl_sync_q <= 2'b11;
            sda_tap_q  <= 2'b11;
            scl_tap_q  <= 2'b11;
            sda_f_q    <= 1'b1;
            scl_f_q    <= 1'b1;
            sda_d_q    <= 1'b1;
            scl_d_q    <= 1'b1;
        end else begin
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_tap_q  <= {sda_tap_q[0], sda_sync_q[1]};
            scl_tap_q  <= {scl_tap_q[0], scl_sync_q[1]};
            sda_f_q    <= sda_maj;
            scl_f_q    <= scl_maj;
            sda_d_q    <= sda_f_q;
            scl_d_q    <= scl_f_q;
        end
    end

    logic scl_rise, scl_fall, sda_rise, sda_fall, start_c, stop_c;

    assign scl_rise = scl_f_q & ~scl_d_q;
    assign scl_fall = ~scl_f_q & scl_d_q;
    assign sda_rise = sda_f_q & ~sda_d_q;
    assign sda_fall = ~sda_f_q & sda_d_q;
    // SCL must already have been high a cycle: releasing the stretch moves SCL and
    // the first read bit on SDA in the same cycle, which is not a bus condition.
    assign start_c  = sda_fall & scl_f_q & scl_d_q;
    assign stop_c   = sda_rise & scl_f_q & scl_d_q;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] sh_q, sh_d, rx_data_q, rx_data_d;
    logic       pend_q, pend_d, rw_q, rw_d, rx_valid_q, rx_valid_d;
    logic       sda_oe_q, sda_oe_d, scl_oe_q, scl_oe_d;
    logic       start_q, start_d, stop_q, stop_d, busy_q, busy_d;

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            sh_q       <= 8'h00;
            rx_data_q  <= 8'h00;
            pend_q     <= 1'b0;
            rw_q       <= 1'b0;
            rx_valid_q <= 1'b0;
            sda_oe_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            rx_data_q  <= rx_data_d;
            pend_q     <= pend_d;
            rw_q       <= rw_d;
            rx_valid_q <= rx_valid_d;
            sda_oe_q   <= sda_oe_d;
            scl_oe_q   <= scl_oe_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic; bus conditions override every state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        rx_data_d  = rx_data_q;
        pend_d     = pend_q;
        rw_d       = rw_q;
        rx_valid_d = 1'b0;
        sda_oe_d   = sda_oe_q;
        scl_oe_d   = scl_oe_q;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        busy_d     = busy_q;
        if (start_c) begin
            state_d  = StAddr;
            cnt_d    = 3'd0;
            pend_d   = 1'b0;
            sda_oe_d = 1'b0;
            scl_oe_d = 1'b0;
            start_d  = 1'b1;
            busy_d   = 1'b1;
        end else if (stop_c) begin
            state_d  = StIdle;
            pend_d   = 1'b0;
            sda_oe_d = 1'b0;
            scl_oe_d = 1'b0;
            stop_d   = 1'b1;
            busy_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StWaitStop: begin
                    sda_oe_d = 1'b0;
                    scl_oe_d = 1'b0;
                end
                StAddr, StWrData: begin
                    if (scl_rise && !pend_q) begin
                        sh_d  = {sh_q[6:0], sda_f_q};
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (state_q == StWrData) begin
                                rx_data_d  = {sh_q[6:0], sda_f_q};
                                rx_valid_d = 1'b1;
                                pend_d     = 1'b1;
                            end else if (sh_q[6:0] == SLAVE_ADDR) begin
                                rw_d   = sda_f_q;
                                pend_d = 1'b1;
                            end else begin
                                state_d = StWaitStop;
                            end
                        end
                    end else if (scl_fall && pend_q) begin
                        pend_d   = 1'b0;
                        sda_oe_d = 1'b1;
                        state_d  = (state_q == StAddr) ? StAddrAck : StWrAck;
                    end
                end
                StAddrAck, StWrAck: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 3'd0;
                        if (state_q == StAddrAck && rw_q) begin
                            state_d  = StRdLoad;
                            scl_oe_d = STRETCH_EN && !tx_valid_i;
                        end else begin
                            state_d = StWrData;
                        end
                    end
                end
                StRdLoad: begin
                    if (tx_valid_i) begin
                        sh_d     = tx_data_i;
                        sda_oe_d = !tx_data_i[7];
                        scl_oe_d = 1'b0;
                        cnt_d    = 3'd0;
                        state_d  = StRdData;
                    end else if (!STRETCH_EN) begin
                        sh_d     = 8'hFF;
                        sda_oe_d = 1'b0;
                        cnt_d    = 3'd0;
                        state_d  = StRdData;
                    end
                end
                StRdData: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd7) begin
                            sda_oe_d = 1'b0;
                            pend_d   = 1'b0;
                            state_d  = StRdAck;
                        end else begin
                            sh_d     = {sh_q[6:0], 1'b0};
                            sda_oe_d = !sh_q[6];
                            cnt_d    = cnt_q + 3'd1;
                        end
                    end
                end
                StRdAck: begin
                    if (scl_rise) begin
                        if (sda_f_q) state_d = StWaitStop;
                        else pend_d = 1'b1;
                    end else if (scl_fall && pend_q) begin
                        pend_d   = 1'b0;
                        state_d  = StRdLoad;
                        scl_oe_d = STRETCH_EN && !tx_valid_i;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign sda_o      = 1'b0;
    assign scl_o      = 1'b0;
    assign sda_oe     = sda_oe_q;
    assign scl_oe     = scl_oe_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;
    assign busy_o     = busy_q;
    assign rw_o       = rw_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign tx_ready_o = (state_q == StRdLoad);

endmodule

// File: tb/tb_i2c_slave_phy.sv
// Self-checking bench for i2c_slave_phy: a bus-level master drives the open-drain
// lines while a transaction model predicts ACKs and received write bytes.
module tb_i2c_slave_phy;

    localparam int Q = 8;  // quarter SCL period in clk_i cycles

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       sda_i, scl_i, sda_o, sda_oe, scl_o, scl_oe;
    logic       start_o, stop_o, busy_o, rw_o, rx_valid_o, tx_ready_o;
    logic [7:0] rx_data_o;
    logic [7:0] tx_data_i = 8'h00;
    logic       tx_valid_i = 1'b0;

    logic m_sda = 1'b1, m_scl = 1'b1, sda_glitch = 1'b0;

    assign sda_i = (m_sda ^ sda_glitch) & ~sda_oe;
    assign scl_i = m_scl & ~scl_oe;

    always #5 clk_i = ~clk_i;

    i2c_slave_phy dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .sda_i      (sda_i),
        .sda_o      (sda_o),
        .sda_oe     (sda_oe),
        .scl_i      (scl_i),
        .scl_o      (scl_o),
        .scl_oe     (scl_oe),
        .start_o    (start_o),
        .stop_o     (stop_o),
        .busy_o     (busy_o),
        .rw_o       (rw_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .tx_data_i  (tx_data_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o)
    );

    int errors = 0, checks = 0;
    int n_start = 0, n_stop = 0, n_stretch = 0;
    logic [7:0] rx_exp[$];
    bit model_first = 1'b0, model_wr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare: constant lines, received bytes against the model queue.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            check("const_lines", {sda_o, scl_o}, 0);
            if (rx_valid_o) begin
                if (rx_exp.size() == 0) check("rx_unexpected", rx_data_o, 32'hFFFF_FFFF);
                else check("rx_data", rx_data_o, rx_exp.pop_front());
            end
            if (start_o) n_start++;
            if (stop_o) n_stop++;
            if (scl_oe) n_stretch++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic scl_up();
        int n = 0;
        m_scl = 1'b1;
        while (scl_i !== 1'b1 && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        if (scl_i !== 1'b1) check("scl_release_timeout", scl_i, 1);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; idle(Q);
        scl_up(); idle(Q);
        m_sda = 1'b0; idle(Q);
        m_scl = 1'b0; idle(Q);
        model_first = 1'b1;
        model_wr    = 1'b0;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; idle(Q);
        scl_up(); idle(Q);
        m_sda = 1'b1; idle(2 * Q);
        model_first = 1'b0;
        model_wr    = 1'b0;
    endtask

    task automatic write_bit(input logic b);
        m_sda = b; idle(Q);
        scl_up(); idle(2 * Q);
        m_scl = 1'b0; idle(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; idle(Q);
        scl_up(); idle(Q);
        b = sda_i; idle(Q);
        m_scl = 1'b0; idle(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic exp_ack, b;
        if (model_first) begin
            exp_ack     = (d[7:1] == 7'h50);
            model_wr    = exp_ack && !d[0];
            model_first = 1'b0;
        end else begin
            exp_ack = model_wr;
            if (model_wr) rx_exp.push_back(d);
        end
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = !b;
        check("ack", ack, exp_ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(!ack);
    endtask

    task automatic provide(input logic [7:0] d, input int dly);
        int n = 0;
        while (tx_ready_o !== 1'b1 && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        check("tx_ready_seen", tx_ready_o, 1);
        idle(dly);
        check("tx_ready_held", tx_ready_o, 1);
        tx_data_i  = d;
        tx_valid_i = 1'b1;
        @(negedge clk_i);
        tx_valid_i = 1'b0;
        check("tx_ready_after", tx_ready_o, 0);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] rd;
        int s0, p0;

        idle(5);
        check("rst_oe", {sda_oe, scl_oe}, 0);
        check("rst_pulses", {start_o, stop_o, rx_valid_o}, 0);
        check("rst_status", {busy_o, rw_o, tx_ready_o}, 0);
        check("rst_rx_data", rx_data_o, 0);
        rst_i = 1'b0;
        idle(20);

        // Plain write of two bytes.
        s0 = n_start; p0 = n_stop;
        i2c_start();
        check("wr_busy", busy_o, 1);
        write_byte(8'hA0, ack); check("wr_addr_ack_lit", ack, 1);
        check("wr_rw", rw_o, 0);
        write_byte(8'h12, ack); check("wr_d0_ack_lit", ack, 1);
        write_byte(8'h34, ack);
        i2c_stop();
        check("wr_start_cnt", n_start - s0, 1);
        check("wr_stop_cnt", n_stop - p0, 1);
        check("wr_busy_end", busy_o, 0);
        check("wr_rx_drained", rx_exp.size(), 0);

        // Address mismatch: no ACK, nothing delivered, parked until STOP.
        i2c_start();
        write_byte(8'hA2, ack); check("nm_addr_ack_lit", ack, 0);
        write_byte(8'h55, ack);
        check("nm_busy", busy_o, 1);
        check("nm_tx_ready", tx_ready_o, 0);
        i2c_stop();
        check("nm_busy_end", busy_o, 0);

        // Read with a 50-cycle late byte: SCL stretched meanwhile.
        i2c_start();
        n_stretch = 0;
        write_byte(8'hA1, ack); check("rd_addr_ack_lit", ack, 1);
        check("rd_rw", rw_o, 1);
        fork
            provide(8'h5A, 50);
            read_byte(rd, 1'b0);
        join
        check("rd_data", rd, 8'h5A);
        check("rd_stretch_len", (n_stretch >= 45 && n_stretch <= 60), 1);
        idle(Q);
        check("rd_nack_ready", tx_ready_o, 0);
        check("rd_nack_sda", sda_oe, 0);
        i2c_stop();

        // Repeated START: write then read in one bus tenure.
        s0 = n_start; p0 = n_stop;
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h12, ack);
        i2c_start();
        write_byte(8'hA1, ack); check("rs_addr_ack_lit", ack, 1);
        check("rs_rw", rw_o, 1);
        check("rs_start_cnt", n_start - s0, 2);
        fork
            provide(8'hC3, 3);
            read_byte(rd, 1'b0);
        join
        check("rs_data", rd, 8'hC3);
        i2c_stop();
        check("rs_stop_cnt", n_stop - p0, 1);

        // STOP mid-byte after a rejected SDA glitch, then a START-shaped glitch.
        s0 = n_start; p0 = n_stop;
        i2c_start();
        write_byte(8'hA0, ack);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
        m_sda = 1'b0; idle(Q);
        scl_up(); idle(Q);
        sda_glitch = 1'b1; idle(1); sda_glitch = 1'b0;
        idle(Q);
        check("gl_no_stop", n_stop - p0, 0);
        m_sda = 1'b1; idle(2 * Q);
        check("gl_stop_cnt", n_stop - p0, 1);
        check("gl_busy", busy_o, 0);
        sda_glitch = 1'b1; idle(1); sda_glitch = 1'b0;
        idle(2 * Q);
        check("gl_start_cnt", n_start - s0, 1);
        check("gl_busy_after", busy_o, 0);
        model_first = 1'b0;

        // Reset while driving the address ACK, then a normal transfer.
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(1'(8'hA0 >> i));
        m_sda = 1'b1; idle(Q);
        scl_up(); idle(Q);
        check("ra_ack_drive", sda_oe, 1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        check("ra_sda_rel", sda_oe, 0);
        check("ra_scl_rel", scl_oe, 0);
        check("ra_busy", busy_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        idle(Q);
        m_scl = 1'b0; idle(Q);
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, ack); check("ra_addr_ack_lit", ack, 1);
        write_byte(8'h77, ack); check("ra_d_ack_lit", ack, 1);
        i2c_stop();
        check("ra_busy_end", busy_o, 0);

        idle(10);
        check("rx_leftover", rx_exp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
